// File: rtl/io_port_responder.sv
// io_port_responder: device-side responder for the CPU programmed-I/O handshakes.
// The input channel answers inp_req from an RX FIFO that the host fills. The
// output channel captures out_data into a TX FIFO that the host drains.
// Optional feature: define IO_PORT_TIMEOUT_EN to time out input requests that
// wait on an empty RX FIFO. A timed-out request returns all-ones and sets the
// sticky err_timeout flag.
module io_port_responder #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  inp_req,
    output logic                  inp_ack,
    output logic [WIDTH-1:0]      inp_data,
    input  logic                  out_req,
    input  logic [WIDTH-1:0]      out_data,
    output logic                  out_ack,
    input  logic                  host_wr_valid,
    input  logic [WIDTH-1:0]      host_wr_data,
    output logic                  host_wr_ready,
    output logic                  host_rd_valid,
    output logic [WIDTH-1:0]      host_rd_data,
    input  logic                  host_rd_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  err_timeout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IN_IDLE, IN_ACK, IN_RELEASE} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_ACK, OUT_RELEASE} out_state_t;

    in_state_t  in_state;
    out_state_t out_state;

    logic [WIDTH-1:0]    rx_mem [DEPTH];
    logic [WIDTH-1:0]    tx_mem [DEPTH];
    logic [DEPTH_LOG2:0] rx_wr_ptr, rx_rd_ptr;
    logic [DEPTH_LOG2:0] tx_wr_ptr, tx_rd_ptr;

    logic rx_push, rx_pop, tx_push, tx_pop;
    logic timeout_hit;

    // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
    assign rx_count      = rx_wr_ptr - rx_rd_ptr;
    assign tx_count      = tx_wr_ptr - tx_rd_ptr;
    assign host_wr_ready = (rx_count < DEPTH_CNT);
    assign host_rd_valid = (tx_count != '0);
    assign host_rd_data  = tx_mem[tx_rd_ptr[DEPTH_LOG2-1:0]];

    // Full and empty are taken from registered counts, so there is no same-cycle bypass.
    assign rx_push = host_wr_valid && host_wr_ready;
    assign rx_pop  = (in_state == IN_IDLE) && inp_req && (rx_count != '0);
    assign tx_push = (out_state == OUT_IDLE) && out_req && (tx_count < DEPTH_CNT);
    assign tx_pop  = host_rd_ready && host_rd_valid;

`ifdef IO_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          waiting;

    assign waiting     = (in_state == IN_IDLE) && inp_req && (rx_count == '0);
    assign timeout_hit = waiting && (wait_cnt == TW'(TIMEOUT));

    // Count cycles spent waiting on an empty RX FIFO; remember any timeout until reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (waiting && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;

    // Without the timeout the CPU simply waits; the parameter stays referenced for both builds.
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    // RX storage is written by the host; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr[DEPTH_LOG2-1:0]] <= host_wr_data;
    end

    // TX storage captures the CPU word sampled at the accepting edge.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr[DEPTH_LOG2-1:0]] <= out_data;
    end

    // FIFO pointers advance independently, so a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // Input handshake: pop one word per request level, pulse the ack, then wait for the request to drop.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_state <= IN_IDLE;
            inp_ack  <= 1'b0;
            inp_data <= '0;
        end else begin
            inp_ack <= 1'b0;
            case (in_state)
                IN_IDLE: begin
                    if (rx_pop) begin
                        inp_data <= rx_mem[rx_rd_ptr[DEPTH_LOG2-1:0]];
                        inp_ack  <= 1'b1;
                        in_state <= IN_ACK;
                    end else if (timeout_hit) begin
                        inp_data <= '1;
                        inp_ack  <= 1'b1;
                        in_state <= IN_ACK;
                    end
                end
                IN_ACK:     in_state <= IN_RELEASE;
                IN_RELEASE: if (!inp_req) in_state <= IN_IDLE;
                default:    in_state <= IN_IDLE;
            endcase
        end
    end

    // Output handshake: capture one word per request level, withholding the ack while TX is full.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_state <= OUT_IDLE;
            out_ack   <= 1'b0;
        end else begin
            out_ack <= 1'b0;
            case (out_state)
                OUT_IDLE: begin
                    if (tx_push) begin
                        out_ack   <= 1'b1;
                        out_state <= OUT_ACK;
                    end
                end
                OUT_ACK:     out_state <= OUT_RELEASE;
                OUT_RELEASE: if (!out_req) out_state <= OUT_IDLE;
                default:     out_state <= OUT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: scoreboard bench for io_port_responder.
// Expected CPU input words and host-read words are queued as stimulus is issued.
// A negedge monitor pops and compares them whenever the DUT acks or the host pops.
module tb_io_port_responder;

    localparam int WIDTH = 16;
    localparam int DL    = 3;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              inp_req;
    logic              inp_ack;
    logic [WIDTH-1:0]  inp_data;
    logic              out_req;
    logic [WIDTH-1:0]  out_data;
    logic              out_ack;
    logic              host_wr_valid;
    logic [WIDTH-1:0]  host_wr_data;
    logic              host_wr_ready;
    logic              host_rd_valid;
    logic [WIDTH-1:0]  host_rd_data;
    logic              host_rd_ready;
    logic [DL:0]       rx_count;
    logic [DL:0]       tx_count;
    logic              err_timeout;

    logic [WIDTH-1:0]  exp_inp[$];
    logic [WIDTH-1:0]  exp_tx[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int inp_ack_cnt  = 0;
    int out_ack_cnt  = 0;

    io_port_responder #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .TIMEOUT(16)) dut (
        .clk(clk), .rst_b(rst_b),
        .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
        .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_ready(host_rd_ready),
        .rx_count(rx_count), .tx_count(tx_count), .err_timeout(err_timeout)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_push(input logic [WIDTH-1:0] d);
        host_wr_valid = 1'b1;
        host_wr_data  = d;
        step(1);
        host_wr_valid = 1'b0;
    endtask

    task automatic apply_stimulus_out(input logic [WIDTH-1:0] d);
        out_req  = 1'b1;
        out_data = d;
        exp_tx.push_back(d);
        step(1);
        out_req = 1'b0;
        step(2);
    endtask

    // Scoreboard monitor: compare every ack'd input word and every host-popped TX word.
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (inp_ack) begin
                inp_ack_cnt++;
                if (exp_inp.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL inp_ack_unexpected: got ack with data %0h expected no ack", inp_data);
                end else begin
                    check_output("inp_data", inp_data, exp_inp.pop_front());
                end
            end
            if (out_ack)
                out_ack_cnt++;
            if (host_rd_valid && host_rd_ready) begin
                if (exp_tx.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL host_rd_unexpected: got pop of %0h expected no data", host_rd_data);
                end else begin
                    check_output("host_rd_data", host_rd_data, exp_tx.pop_front());
                end
            end
        end
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int base;
        rst_b = 1'b0; inp_req = 1'b0; out_req = 1'b0; out_data = '0;
        host_wr_valid = 1'b0; host_wr_data = '0; host_rd_ready = 1'b0;
        step(3);
        check_output("rst_inp_ack", inp_ack, 0);
        check_output("rst_out_ack", out_ack, 0);
        check_output("rst_inp_data", inp_data, 0);
        check_output("rst_rx_count", rx_count, 0);
        check_output("rst_tx_count", tx_count, 0);
        check_output("rst_wr_ready", host_wr_ready, 1);
        check_output("rst_rd_valid", host_rd_valid, 0);
        check_output("rst_err_timeout", err_timeout, 0);
        rst_b = 1'b1;
        step(2);

        // Two queued words, two separate request levels.
        host_push(16'h1234); exp_inp.push_back(16'h1234);
        host_push(16'hABCD); exp_inp.push_back(16'hABCD);
        check_output("rx_count_two", rx_count, 2);
        inp_req = 1'b1;
        step(1);
        check_output("inp_ack_latency", inp_ack, 1);
        step(1);
        check_output("inp_ack_one_cycle", inp_ack, 0);
        step(3);
        inp_req = 1'b0;
        step(2);
        inp_req = 1'b1;
        step(1);
        check_output("inp_ack_second", inp_ack, 1);
        inp_req = 1'b0;
        step(2);
        check_output("rx_count_drained", rx_count, 0);
        check_output("inp_ack_count_2", inp_ack_cnt, 2);
        check_output("inp_data_hold", inp_data, 16'hABCD);

        // One word, request held for ten cycles: exactly one ack.
        host_push(16'h5A5A); exp_inp.push_back(16'h5A5A);
        inp_req = 1'b1;
        step(10);
        inp_req = 1'b0;
        step(2);
        check_output("inp_ack_single_pulse", inp_ack_cnt, 3);

        // Fill TX with 0..7, then a ninth word must wait for space.
        for (int i = 0; i < 8; i++)
            apply_stimulus_out(WIDTH'(i));
        check_output("out_ack_count_8", out_ack_cnt, 8);
        check_output("tx_count_full", tx_count, 8);
        check_output("rd_valid_full", host_rd_valid, 1);
        out_req = 1'b1; out_data = 16'd9; exp_tx.push_back(16'd9);
        step(4);
        check_output("out_ack_withheld", out_ack_cnt, 8);
        check_output("tx_count_still_full", tx_count, 8);
        host_rd_ready = 1'b1;
        step(1);
        host_rd_ready = 1'b0;
        base = 0;
        while (out_ack_cnt < 9 && base < 6) begin
            step(1);
            base++;
        end
        check_output("out_ack_after_space", out_ack_cnt, 9);
        out_req = 1'b0;
        step(2);
        check_output("tx_count_refilled", tx_count, 8);
        host_rd_ready = 1'b1;
        base = 0;
        while (host_rd_valid && base < 20) begin
            step(1);
            base++;
        end
        host_rd_ready = 1'b0;
        check_output("tx_count_drained", tx_count, 0);
        check_output("tx_scoreboard_empty", exp_tx.size(), 0);

        // RX full with host push and CPU pop in the same cycle: push rejected.
        for (int i = 1; i <= 8; i++) begin
            host_push(WIDTH'(i * 16'h0111));
            exp_inp.push_back(WIDTH'(i * 16'h0111));
        end
        check_output("rx_count_full", rx_count, 8);
        check_output("wr_ready_full", host_wr_ready, 0);
        host_wr_valid = 1'b1; host_wr_data = 16'h9999;
        inp_req = 1'b1;
        step(1);
        host_wr_valid = 1'b0;
        check_output("rx_count_after_race", rx_count, 7);
        inp_req = 1'b0;
        step(2);
        check_output("rx_count_no_late_push", rx_count, 7);

        // Reset during IN_ACK aborts the handshake and discards FIFO contents.
        inp_req = 1'b1;
        step(1);
        check_output("inp_ack_before_reset", inp_ack, 1);
        rst_b = 1'b0;
        #1;
        check_output("reset_kills_ack", inp_ack, 0);
        check_output("reset_rx_count", rx_count, 0);
        check_output("reset_tx_count", tx_count, 0);
        check_output("reset_inp_data", inp_data, 0);
        check_output("reset_wr_ready", host_wr_ready, 1);
        exp_inp.delete();
        inp_req = 1'b0;
        step(1);
        rst_b = 1'b1;
        step(1);
        host_push(16'h7777); exp_inp.push_back(16'h7777);
        inp_req = 1'b1;
        step(1);
        check_output("idle_after_reset", inp_ack, 1);
        inp_req = 1'b0;
        step(2);

        // Request on an empty RX FIFO.
        base = inp_ack_cnt;
`ifdef IO_PORT_TIMEOUT_EN
        exp_inp.push_back(16'hFFFF);
        inp_req = 1'b1;
        step(16);
        check_output("timeout_not_early", inp_ack, 0);
        step(1);
        check_output("timeout_ack", inp_ack, 1);
        check_output("timeout_err", err_timeout, 1);
        inp_req = 1'b0;
        step(3);
        check_output("timeout_err_sticky", err_timeout, 1);
        check_output("timeout_ack_count", inp_ack_cnt, base + 1);
`else
        inp_req = 1'b1;
        step(100);
        check_output("no_timeout_ack", inp_ack_cnt, base);
        check_output("no_timeout_err", err_timeout, 0);
        inp_req = 1'b0;
        step(2);
`endif
        check_output("inp_scoreboard_empty", exp_inp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
